// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer: streams input/weight chunks into FC_compute,
// accumulates chunk dot products on a per-neuron bias and writes fp16 results.
module fc_layer_sequencer #(
    parameter int DATAWIDTH      = 16,
    parameter int Mult_Add_Units = 16,
    parameter int CNT_W          = 10,
    parameter int W_ADDR_W       = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [CNT_W-1:0]                    num_chunks,
    input  logic [CNT_W-1:0]                    num_outputs,
    input  logic                                relu_en,
    output logic                                busy,
    output logic                                done,
    output logic                                in_rd_en,
    output logic [CNT_W-1:0]                    in_addr,
    input  logic [DATAWIDTH*Mult_Add_Units-1:0] in_data,
    output logic                                w_rd_en,
    output logic [W_ADDR_W-1:0]                 w_addr,
    input  logic [DATAWIDTH*Mult_Add_Units-1:0] w_data,
    output logic                                bias_rd_en,
    output logic [CNT_W-1:0]                    bias_addr,
    input  logic [DATAWIDTH-1:0]                bias_data,
    output logic [DATAWIDTH*Mult_Add_Units-1:0] fc_input_data,
    output logic [DATAWIDTH*Mult_Add_Units-1:0] fc_weights,
    input  logic [DATAWIDTH-1:0]                fc_result,
    output logic                                out_wr_en,
    output logic [CNT_W-1:0]                    out_addr,
    output logic [DATAWIDTH-1:0]                out_data
);

    typedef enum logic [2:0] {
        IDLE, LOAD_BIAS, STREAM, DRAIN, WRITE, DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     n_q, m_q, j;
    logic                 relu_q;
    logic [W_ADDR_W-1:0]  wcnt;
    logic                 dcnt;
    logic [1:0]           vld;
    logic                 bias_pend;
    logic [DATAWIDTH-1:0] acc, acc_next, res;

    // fp16 adder, round-to-nearest-even, inf/nan passed through
    function automatic logic [15:0] fadd16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [13:0] mx, my, lost;
        logic [14:0] s;
        logic [11:0] m;
        logic        rnd;
        int          e, d;
        if (a[14:10] == 5'h1f) return a;
        if (b[14:10] == 5'h1f) return b;
        if (a[14:0] >= b[14:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        mx = {x[14:10] != 5'd0, x[9:0], 3'b000};
        my = {y[14:10] != 5'd0, y[9:0], 3'b000};
        e  = (x[14:10] == 5'd0) ? 1 : int'(x[14:10]);
        d  = e - ((y[14:10] == 5'd0) ? 1 : int'(y[14:10]));
        if (d > 13) begin
            my = {13'd0, |my};
        end else begin
            lost = my & ((14'd1 << d) - 14'd1);
            my   = (my >> d) | {13'd0, |lost};
        end
        if (x[15] == y[15]) s = {1'b0, mx} + {1'b0, my};
        else s = {1'b0, mx} - {1'b0, my};
        if (s == 15'd0) return 16'h0000;
        if (s[14]) begin
            s = {1'b0, s[14:2], s[1] | s[0]};
            e = e + 1;
        end
        for (int i = 0; i < 13; i++) begin
            if (!s[13] && e > 1) begin
                s = s << 1;
                e = e - 1;
            end
        end
        rnd = s[2] & (s[1] | s[0] | s[3]);
        m   = {1'b0, s[13:3]} + {11'd0, rnd};
        if (m[11]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 31) return {x[15], 5'h1f, 10'h000};
        return {x[15], m[10] ? 5'(e) : 5'd0, m[9:0]};
    endfunction

    // bias load and first accumulate are two cycles apart, never colliding
    always_comb begin
        acc_next = acc;
        if (bias_pend) acc_next = bias_data;
        else if (vld[1]) acc_next = fadd16(acc, fc_result);
        res = (relu_q && acc_next[15]) ? '0 : acc_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld           <= '0;
            bias_pend     <= 1'b0;
            acc           <= '0;
            fc_input_data <= '0;
            fc_weights    <= '0;
        end else begin
            vld       <= {vld[0], in_rd_en};
            bias_pend <= bias_rd_en;
            acc       <= acc_next;
            if (vld[0]) begin
                fc_input_data <= in_data;
                fc_weights    <= w_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            n_q        <= '0;
            m_q        <= '0;
            j          <= '0;
            relu_q     <= 1'b0;
            wcnt       <= '0;
            dcnt       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            in_rd_en   <= 1'b0;
            in_addr    <= '0;
            w_rd_en    <= 1'b0;
            w_addr     <= '0;
            bias_rd_en <= 1'b0;
            bias_addr  <= '0;
            out_wr_en  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    n_q    <= num_chunks;
                    m_q    <= num_outputs;
                    relu_q <= relu_en;
                    j      <= '0;
                    wcnt   <= '0;
                    busy   <= 1'b1;
                    if (num_outputs == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= LOAD_BIAS;
                        bias_rd_en <= 1'b1;
                        bias_addr  <= '0;
                    end
                end
                LOAD_BIAS: begin
                    bias_rd_en <= 1'b0;
                    dcnt       <= 1'b0;
                    if (n_q == '0) begin
                        state <= DRAIN;
                    end else begin
                        state    <= STREAM;
                        in_rd_en <= 1'b1;
                        w_rd_en  <= 1'b1;
                        in_addr  <= '0;
                        w_addr   <= wcnt;
                        wcnt     <= wcnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (in_addr == n_q - 1'b1) begin
                        state    <= DRAIN;
                        in_rd_en <= 1'b0;
                        w_rd_en  <= 1'b0;
                    end else begin
                        in_addr <= in_addr + 1'b1;
                        w_addr  <= wcnt;
                        wcnt    <= wcnt + 1'b1;
                    end
                end
                DRAIN: begin
                    dcnt <= 1'b1;
                    if (dcnt) begin
                        state     <= WRITE;
                        out_wr_en <= 1'b1;
                        out_addr  <= j;
                        out_data  <= res;
                    end
                end
                WRITE: begin
                    out_wr_en <= 1'b0;
                    if (j == m_q - 1'b1) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        j          <= j + 1'b1;
                        state      <= LOAD_BIAS;
                        bias_rd_en <= 1'b1;
                        bias_addr  <= j + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
